// File: rtl/ins_decode_unit.sv
// ins_decode_unit
//   Decode / register-read stage sitting directly behind instruction fetch.
//   Splits the fetched word into fields, classifies the opcode, reads the
//   internal register file (with write-through from the writeback port) and
//   registers the resulting ID/EX bundle for execute. A load in ID/EX whose
//   destination feeds the instruction now in decode raises freeze_out so fetch
//   holds its word for one cycle while a bubble is inserted.
//
// Ports
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   ins_in, npc_in    instruction word and next-PC from fetch
//   valid_in          ins_in/npc_in carry a real instruction
//   flush_in          taken branch: discard the instruction in decode
//   wb_*_in           writeback port into the register file
//   freeze_out        combinational stall request to fetch
//   valid_out ...     registered ID/EX bundle (operands, immediate, fields,
//                     destination, write/load flags)
//   stall_count_out   saturating count of load-use stall cycles
module ins_decode_unit #(
    parameter int unsigned reg_width  = 32,
    parameter int unsigned bus_width  = 32,
    parameter int unsigned reg_count  = 32,
    parameter int unsigned addr_width = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [bus_width-1:0]  ins_in,
    input  logic [bus_width-1:0]  npc_in,
    input  logic                  valid_in,
    input  logic                  flush_in,
    input  logic                  wb_enable_in,
    input  logic [addr_width-1:0] wb_addr_in,
    input  logic [reg_width-1:0]  wb_data_in,
    output logic                  freeze_out,
    output logic                  valid_out,
    output logic [bus_width-1:0]  npc_out,
    output logic [reg_width-1:0]  a_out,
    output logic [reg_width-1:0]  b_out,
    output logic [reg_width-1:0]  imm_out,
    output logic [5:0]            opcode_out,
    output logic [5:0]            funct_out,
    output logic [addr_width-1:0] dest_out,
    output logic                  writes_reg_out,
    output logic                  is_load_out,
    output logic [15:0]           stall_count_out
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLoad  = 6'b100011;
    localparam logic [5:0] OpStore = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [5:0]            opcode;
    logic [addr_width-1:0] rs;
    logic [addr_width-1:0] rt;
    logic [addr_width-1:0] rd;
    logic [15:0]           imm16;
    logic [5:0]            funct;

    assign opcode = ins_in[31:26];
    assign rs     = ins_in[21 +: addr_width];
    assign rt     = ins_in[16 +: addr_width];
    assign rd     = ins_in[11 +: addr_width];
    assign imm16  = ins_in[15:0];
    assign funct  = ins_in[5:0];

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    logic                  dec_reads_rt;
    logic                  dec_writes;
    logic                  dec_is_load;
    logic [addr_width-1:0] dec_dest;
    logic [reg_width-1:0]  dec_imm;

    always_comb begin
        dec_reads_rt = 1'b0;
        dec_writes   = 1'b1;
        dec_is_load  = 1'b0;
        dec_dest     = rt;
        case (opcode)
            OpRtype: begin
                dec_reads_rt = 1'b1;
                dec_dest     = rd;
            end
            OpLoad: begin
                dec_is_load = 1'b1;
            end
            OpStore, OpBeq: begin
                // Non-writers carry a zero destination so nothing downstream
                // can mistake them for a producer.
                dec_reads_rt = 1'b1;
                dec_writes   = 1'b0;
                dec_dest     = '0;
            end
            default: begin
                // I-type ALU: rs source, rt destination.
            end
        endcase
    end

    always_comb begin
        if (opcode == OpAndi || opcode == OpOri) begin
            dec_imm = {{(reg_width-16){1'b0}}, imm16};
        end else begin
            dec_imm = {{(reg_width-16){imm16[15]}}, imm16};
        end
    end

    // ------------------------------------------------------------------
    // Register file with write-through
    // ------------------------------------------------------------------
    logic [reg_width-1:0] rf_q [reg_count];
    logic [reg_width-1:0] rf_d [reg_count];
    logic                 wb_write;

    assign wb_write = wb_enable_in && (wb_addr_in != '0);

    always_comb begin
        rf_d = rf_q;
        if (wb_write) begin
            rf_d[wb_addr_in] = wb_data_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(reg_count); i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    logic [reg_width-1:0] rs_val;
    logic [reg_width-1:0] rt_val;

    // A register being written this cycle is forwarded straight from the
    // writeback port so the captured operand is never one write stale.
    always_comb begin
        if (rs == '0) begin
            rs_val = '0;
        end else if (wb_write && wb_addr_in == rs) begin
            rs_val = wb_data_in;
        end else begin
            rs_val = rf_q[rs];
        end
    end

    always_comb begin
        if (rt == '0) begin
            rt_val = '0;
        end else if (wb_write && wb_addr_in == rt) begin
            rt_val = wb_data_in;
        end else begin
            rt_val = rf_q[rt];
        end
    end

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    logic                  valid_q,    valid_d;
    logic [bus_width-1:0]  npc_q,      npc_d;
    logic [reg_width-1:0]  a_q,        a_d;
    logic [reg_width-1:0]  b_q,        b_d;
    logic [reg_width-1:0]  imm_q,      imm_d;
    logic [5:0]            opcode_q,   opcode_d;
    logic [5:0]            funct_q,    funct_d;
    logic [addr_width-1:0] dest_q,     dest_d;
    logic                  writes_q,   writes_d;
    logic                  is_load_q,  is_load_d;
    logic [15:0]           stall_cnt_q, stall_cnt_d;

    // Load-use hazard against the bundle now held in ID/EX. Because the
    // resulting bubble clears valid_q, the stall lasts a single cycle.
    logic hazard_src;

    assign hazard_src = (dest_q == rs) || (dec_reads_rt && (dest_q == rt));
    assign freeze_out = valid_in && !flush_in && valid_q && is_load_q &&
                        (dest_q != '0) && hazard_src;

    always_comb begin
        // Bubble by default: control cleared, data fields hold.
        valid_d     = 1'b0;
        writes_d    = 1'b0;
        is_load_d   = 1'b0;
        npc_d       = npc_q;
        a_d         = a_q;
        b_d         = b_q;
        imm_d       = imm_q;
        opcode_d    = opcode_q;
        funct_d     = funct_q;
        dest_d      = dest_q;
        stall_cnt_d = stall_cnt_q;

        if (flush_in) begin
            // bubble
        end else if (freeze_out) begin
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end else if (valid_in) begin
            valid_d   = 1'b1;
            writes_d  = dec_writes;
            is_load_d = dec_is_load;
            npc_d     = npc_in;
            a_d       = rs_val;
            b_d       = rt_val;
            imm_d     = dec_imm;
            opcode_d  = opcode;
            funct_d   = funct;
            dest_d    = dec_dest;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            npc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            opcode_q    <= '0;
            funct_q     <= '0;
            dest_q      <= '0;
            writes_q    <= 1'b0;
            is_load_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            npc_q       <= npc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            imm_q       <= imm_d;
            opcode_q    <= opcode_d;
            funct_q     <= funct_d;
            dest_q      <= dest_d;
            writes_q    <= writes_d;
            is_load_q   <= is_load_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign valid_out       = valid_q;
    assign npc_out         = npc_q;
    assign a_out           = a_q;
    assign b_out           = b_q;
    assign imm_out         = imm_q;
    assign opcode_out      = opcode_q;
    assign funct_out       = funct_q;
    assign dest_out        = dest_q;
    assign writes_reg_out  = writes_q;
    assign is_load_out     = is_load_q;
    assign stall_count_out = stall_cnt_q;

endmodule

// File: tb/tb_ins_decode_unit.sv
// Bench for ins_decode_unit: directed cases for the headline behaviours,
// then randomized traffic compared against a behavioural model.
module tb_ins_decode_unit;

    logic        clock;
    logic        reset;
    logic [31:0] ins_in;
    logic [31:0] npc_in;
    logic        valid_in;
    logic        flush_in;
    logic        wb_enable_in;
    logic [4:0]  wb_addr_in;
    logic [31:0] wb_data_in;
    logic        freeze_out;
    logic        valid_out;
    logic [31:0] npc_out;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [31:0] imm_out;
    logic [5:0]  opcode_out;
    logic [5:0]  funct_out;
    logic [4:0]  dest_out;
    logic        writes_reg_out;
    logic        is_load_out;
    logic [15:0] stall_count_out;

    ins_decode_unit dut (
        .clock          (clock),
        .reset          (reset),
        .ins_in         (ins_in),
        .npc_in         (npc_in),
        .valid_in       (valid_in),
        .flush_in       (flush_in),
        .wb_enable_in   (wb_enable_in),
        .wb_addr_in     (wb_addr_in),
        .wb_data_in     (wb_data_in),
        .freeze_out     (freeze_out),
        .valid_out      (valid_out),
        .npc_out        (npc_out),
        .a_out          (a_out),
        .b_out          (b_out),
        .imm_out        (imm_out),
        .opcode_out     (opcode_out),
        .funct_out      (funct_out),
        .dest_out       (dest_out),
        .writes_reg_out (writes_reg_out),
        .is_load_out    (is_load_out),
        .stall_count_out(stall_count_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_rf [32];
    logic        e_v, e_wr, e_ld;
    logic [31:0] e_npc, e_a, e_b, e_imm;
    logic [5:0]  e_op, e_fn;
    logic [4:0]  e_dest;
    logic [15:0] e_cnt;
    logic        last_freeze;
    logic        last_model_freeze;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        e_v = 0; e_wr = 0; e_ld = 0; e_npc = 0; e_a = 0; e_b = 0; e_imm = 0;
        e_op = 0; e_fn = 0; e_dest = 0; e_cnt = 0;
    endtask

    function automatic bit reads_rt(input logic [5:0] op);
        return op == 6'h00 || op == 6'h2b || op == 6'h04;
    endfunction

    function automatic bit writes_of(input logic [5:0] op);
        return !(op == 6'h2b || op == 6'h04);
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] r, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (r == 0) return 32'h0;
        if (we && wa == r) return wd;
        return m_rf[r];
    endfunction

    function automatic bit model_freeze(input logic [31:0] ins, input logic v, input logic fl);
        logic [5:0] op = ins[31:26];
        logic [4:0] rs = ins[25:21];
        logic [4:0] rt = ins[20:16];
        if (!v || fl || !e_v || !e_ld || e_dest == 0) return 0;
        return (e_dest == rs) || (reads_rt(op) && e_dest == rt);
    endfunction

    task automatic model_clock(input logic [31:0] ins, input logic [31:0] npc, input logic v,
                               input logic fl, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input bit mf);
        logic [5:0] op = ins[31:26];
        logic [15:0] im = ins[15:0];
        if (fl || mf || !v) begin
            e_v = 0; e_wr = 0; e_ld = 0;
            if (!fl && mf && e_cnt != 16'hFFFF) e_cnt = e_cnt + 1;
        end else begin
            e_v   = 1;
            e_npc = npc;
            e_a   = read_reg(ins[25:21], we, wa, wd);
            e_b   = read_reg(ins[20:16], we, wa, wd);
            if (op == 6'h0c || op == 6'h0d) e_imm = {16'h0, im};
            else e_imm = 32'($signed(im));
            e_op  = op;
            e_fn  = ins[5:0];
            e_wr  = writes_of(op);
            e_ld  = (op == 6'h23);
            e_dest = (op == 6'h00) ? ins[15:11] : (e_wr ? ins[20:16] : 5'd0);
        end
        if (we && wa != 0) m_rf[wa] = wd;
    endtask

    task automatic check_bundle();
        check_eq("valid_out", 32'(valid_out), 32'(e_v));
        check_eq("writes_reg_out", 32'(writes_reg_out), 32'(e_wr));
        check_eq("is_load_out", 32'(is_load_out), 32'(e_ld));
        check_eq("stall_count_out", 32'(stall_count_out), 32'(e_cnt));
        check_eq("npc_out", npc_out, e_npc);
        check_eq("a_out", a_out, e_a);
        check_eq("b_out", b_out, e_b);
        check_eq("imm_out", imm_out, e_imm);
        check_eq("opcode_out", 32'(opcode_out), 32'(e_op));
        check_eq("funct_out", 32'(funct_out), 32'(e_fn));
        if (e_v && e_wr) check_eq("dest_out", 32'(dest_out), 32'(e_dest));
    endtask

    // One cycle: drive at negedge, check freeze, clock, check the bundle.
    task automatic step(input logic [31:0] ins, input logic [31:0] npc, input logic v,
                        input logic fl, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd);
        bit mf;
        @(negedge clock);
        ins_in = ins; npc_in = npc; valid_in = v; flush_in = fl;
        wb_enable_in = we; wb_addr_in = wa; wb_data_in = wd;
        #1;
        mf = model_freeze(ins, v, fl);
        last_freeze = freeze_out;
        last_model_freeze = mf;
        check_eq("freeze_out", 32'(freeze_out), 32'(mf));
        @(posedge clock);
        model_clock(ins, npc, v, fl, we, wa, wd, mf);
        #1;
        check_bundle();
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [5:0] op_tab [8];
    logic [31:0] cur_ins, cur_npc, ld, use_ins;
    logic [15:0] cnt_before;

    initial begin
        op_tab[0] = 6'h00; op_tab[1] = 6'h23; op_tab[2] = 6'h2b; op_tab[3] = 6'h04;
        op_tab[4] = 6'h0c; op_tab[5] = 6'h0d; op_tab[6] = 6'h08; op_tab[7] = 6'h23;
        reset = 0; ins_in = 0; npc_in = 0; valid_in = 0; flush_in = 0;
        wb_enable_in = 0; wb_addr_in = 0; wb_data_in = 0;
        model_reset();
        #3;
        check_eq("reset valid_out", 32'(valid_out), 0);
        check_eq("reset freeze_out", 32'(freeze_out), 0);
        check_eq("reset stall_count", 32'(stall_count_out), 0);
        @(negedge clock);
        reset = 1;

        // Writeback then read
        step(32'h0, 32'h0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        step(r_ins(5'd5, 5'd0, 5'd3, 6'h20), 32'h104, 1, 0, 0, 5'd0, 32'h0);
        check_eq("rtype a_out", a_out, 32'hDEADBEEF);
        check_eq("rtype b_out", b_out, 32'h0);
        check_eq("rtype dest_out", 32'(dest_out), 32'd3);
        check_eq("rtype writes", 32'(writes_reg_out), 1);
        check_eq("rtype valid", 32'(valid_out), 1);

        // Write-through and r0
        step(r_ins(5'd7, 5'd5, 5'd1, 6'h21), 32'h108, 1, 0, 1, 5'd7, 32'h1234);
        check_eq("write-through a_out", a_out, 32'h1234);
        step(32'h0, 32'h0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
        step(r_ins(5'd0, 5'd0, 5'd2, 6'h20), 32'h110, 1, 0, 0, 5'd0, 32'h0);
        check_eq("r0 read", a_out, 32'h0);

        // Immediates
        step(i_ins(6'h23, 5'd1, 5'd9, 16'h8000), 32'h114, 1, 0, 0, 5'd0, 32'h0);
        check_eq("load imm", imm_out, 32'hFFFF8000);
        check_eq("load is_load", 32'(is_load_out), 1);
        check_eq("load dest", 32'(dest_out), 32'd9);
        step(i_ins(6'h0d, 5'd1, 5'd2, 16'h8000), 32'h118, 1, 0, 0, 5'd0, 32'h0);
        check_eq("ori imm", imm_out, 32'h00008000);

        // Load-use stall
        ld = i_ins(6'h23, 5'd1, 5'd4, 16'h0010);
        use_ins = r_ins(5'd4, 5'd2, 5'd6, 6'h20);
        step(ld, 32'h11c, 1, 0, 0, 5'd0, 32'h0);
        step(use_ins, 32'h120, 1, 0, 0, 5'd0, 32'h0);
        check_eq("stall freeze", 32'(last_freeze), 1);
        check_eq("stall bubble", 32'(valid_out), 0);
        step(use_ins, 32'h120, 1, 0, 0, 5'd0, 32'h0);
        check_eq("stall released", 32'(last_freeze), 0);
        check_eq("stall issued", 32'(valid_out), 1);
        check_eq("stall count 1", 32'(stall_count_out), 1);

        // Load to r0 never stalls
        step(i_ins(6'h23, 5'd1, 5'd0, 16'h0), 32'h124, 1, 0, 0, 5'd0, 32'h0);
        step(r_ins(5'd0, 5'd0, 5'd6, 6'h20), 32'h128, 1, 0, 0, 5'd0, 32'h0);
        check_eq("r0 load no stall", 32'(last_freeze), 0);

        // Stall coinciding with flush
        step(i_ins(6'h23, 5'd1, 5'd6, 16'h0), 32'h12c, 1, 0, 0, 5'd0, 32'h0);
        cnt_before = stall_count_out;
        step(r_ins(5'd6, 5'd0, 5'd7, 6'h20), 32'h130, 1, 1, 0, 5'd0, 32'h0);
        check_eq("flush freeze", 32'(last_freeze), 0);
        check_eq("flush bubble", 32'(valid_out), 0);
        check_eq("flush count", 32'(stall_count_out), 32'(cnt_before));

        // Randomized traffic; fetch holds its word while frozen
        cur_ins = 0; cur_npc = 32'h200; last_model_freeze = 0;
        for (int n = 0; n < 400; n++) begin
            logic v, fl, we;
            if (!last_model_freeze) begin
                cur_ins = {op_tab[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)), 16'($urandom)};
                cur_npc = cur_npc + 4;
                v = ($urandom_range(0, 99) < 85);
            end else begin
                v = 1;
            end
            fl = ($urandom_range(0, 99) < 10);
            we = ($urandom_range(0, 99) < 50);
            step(cur_ins, cur_npc, v, fl, we, 5'($urandom_range(0, 7)), $urandom);
        end

        // Reset in the middle of a stall
        step(i_ins(6'h23, 5'd1, 5'd3, 16'h0), 32'h300, 1, 0, 0, 5'd0, 32'h0);
        @(negedge clock);
        ins_in = r_ins(5'd3, 5'd0, 5'd4, 6'h20); npc_in = 32'h304;
        valid_in = 1; flush_in = 0; wb_enable_in = 0;
        #1;
        check_eq("pre-reset freeze", 32'(freeze_out), 1);
        check_eq("pre-reset valid", 32'(valid_out), 1);
        reset = 0;
        #1;
        check_eq("async reset freeze", 32'(freeze_out), 0);
        check_eq("async reset valid", 32'(valid_out), 0);
        check_eq("async reset a_out", a_out, 0);
        check_eq("async reset npc_out", npc_out, 0);
        check_eq("async reset is_load", 32'(is_load_out), 0);
        check_eq("async reset dest", 32'(dest_out), 0);
        check_eq("async reset count", 32'(stall_count_out), 0);
        model_reset();
        @(negedge clock);
        reset = 1;
        // Held instruction now issues cleanly against a cleared register file
        step(r_ins(5'd3, 5'd0, 5'd4, 6'h20), 32'h304, 1, 0, 0, 5'd0, 32'h0);
        check_eq("post-reset issue", 32'(valid_out), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ins_decode_unit.md
Name: ins_decode_unit

Overview:
- Decode/register-read stage, directly downstream of instruction fetch.
- Consumes the fetched instruction word and next-PC.
- Reads the internal register file and produces the registered ID/EX bundle for execute.
- Detects load-use hazards against its own ID/EX register and raises freeze_out to stall fetch.

Parameters:
- reg_width, 32, data and register width
- bus_width, 32, instruction/PC width
- reg_count, 32, number of architectural registers
- addr_width, 5, register index width (log2 reg_count)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- ins_in  input  bus_width  instruction from fetch
- npc_in  input  bus_width  next-PC from fetch
- valid_in  input  1  ins_in/npc_in hold a real instruction
- flush_in  input  1  branch taken: discard current decode
- wb_enable_in  input  1  writeback strobe
- wb_addr_in  input  addr_width  writeback register index
- wb_data_in  input  reg_width  writeback data
- freeze_out  output  1  stall request to fetch (combinational)
- valid_out  output  1  ID/EX bundle valid
- npc_out  output  bus_width  registered npc
- a_out  output  reg_width  rs operand
- b_out  output  reg_width  rt operand
- imm_out  output  reg_width  extended immediate
- opcode_out  output  6  ins[31:26]
- funct_out  output  6  ins[5:0]
- dest_out  output  addr_width  destination register
- writes_reg_out  output  1  instruction writes dest_out
- is_load_out  output  1  instruction is a load
- stall_count_out  output  16  saturating count of stall cycles

Behaviour:
- Fields: opcode=ins[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], funct=[5:0].
- Opcode classes:
  - 000000 R-type: reads rs,rt; dest=rd; writes.
  - 100011 load: reads rs; dest=rt; writes; is_load.
  - 101011 store: reads rs,rt; no write.
  - 000100 beq: reads rs,rt; no write.
  - All others: I-type ALU; reads rs; dest=rt; writes.
- Immediate: zero-extend for 001100 and 001101; sign-extend for all other opcodes.
- Register file:
  - reg_count x reg_width; r0 reads 0 always.
  - Writes to r0 are ignored.
  - Written on posedge when wb_enable_in=1.
  - Write-through: a read of wb_addr_in in the same cycle as its write returns wb_data_in (except r0).
- Hazard: freeze_out = valid_in & !flush_in & valid_out & is_load_out & (dest_out!=0) & ((dest_out==rs) | (dest_out==rt & rt is read)).
- Fetch holds ins_in/npc_in while freeze_out=1.
- ID/EX register update at posedge, in priority order:
  - reset low: all outputs 0, register file cleared, stall_count_out=0.
  - flush_in=1: bubble.
  - freeze_out=1: bubble; stall_count_out+1, saturating at 16'hFFFF.
  - valid_in=1: capture decoded bundle; valid_out=1.
  - else: bubble.
- Bubble definition: valid_out=0, writes_reg_out=0, is_load_out=0. Data fields hold their previous values.
- Latency: 1 cycle from ins_in to the bundle.
- A load-use stall lasts exactly 1 cycle, because the bubble clears valid_out so freeze_out drops.
- Reset mid-stall: freeze_out drops immediately (asynchronous); the fetch-side instruction is retained.

Test Plan:
- Reset low, then high; write r5=32'hDEADBEEF via wb. Next cycle present R-type rs=5 rt=0 rd=3 -> one cycle later a_out=DEADBEEF, b_out=0, dest_out=3, writes_reg_out=1, valid_out=1.
- Same cycle: wb writes r7=32'h1234 while ins reads rs=7 -> a_out=32'h1234 (write-through). Separately, write r0=FFFF_FFFF then read r0 -> 0.
- Immediates: load with imm=16'h8000 -> imm_out=FFFF8000, is_load_out=1, dest_out=rt. ori with imm=16'h8000 -> imm_out=00008000.
- Load r4 followed by R-type with rs=4:
  - freeze_out=1 for exactly 1 cycle; a bubble appears with valid_out=0.
  - The R-type then issues; stall_count_out=1.
  - Repeat with dest r0: no stall.
- Stall and flush_in in the same cycle -> freeze_out=0, bubble, stall_count_out unchanged.
- Assert reset low mid-stream with valid_out=1 -> all outputs 0 immediately, without waiting for a clock edge.
